// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one request in flight on the
// instruction bus and buffers returned words in a small FIFO for the if_id register.
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LVL = FIFO_DEPTH[CW:0];
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic          r_outstanding;
    logic [31:0]   r_out_addr;
    logic          r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_fifo_addr [FIFO_DEPTH];
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];

    logic [31:0]   w_pc_next;
    logic          w_outstanding_next;
    logic [31:0]   w_out_addr_next;
    logic          w_discard_next;
    logic [CW-1:0] w_count_next;
    logic [AW-1:0] w_rd_ptr_next;
    logic [AW-1:0] w_wr_ptr_next;

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_resp;
    logic          w_accept;
    logic [CW:0]   w_level;

    assign w_valid  = (r_count != '0) & ~jump_flag_i & ~rst;
    assign w_pop    = w_valid & ~hold_flag_i & ~jump_flag_i;
    assign w_resp   = ibus_rvalid_i & r_outstanding;
    assign w_push   = w_resp & ~r_discard & ~jump_flag_i;
    // Occupancy after this edge; a new request needs a free slot for its response.
    assign w_level  = {1'b0, r_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};

    assign ibus_req_o  = ~rst & ~jump_flag_i & (~r_outstanding | ibus_rvalid_i) &
                         (w_level < DEPTH_LVL);
    assign ibus_addr_o = r_pc;
    assign w_accept    = ibus_req_o & ibus_ack_i;

    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_fifo_inst[r_rd_ptr] : NOP;
    assign inst_addr_o  = w_valid ? r_fifo_addr[r_rd_ptr] : 32'h0000_0000;

    always_comb begin
        w_pc_next          = r_pc;
        w_outstanding_next = r_outstanding;
        w_out_addr_next    = r_out_addr;
        w_discard_next     = r_discard;
        w_count_next       = r_count;
        w_rd_ptr_next      = r_rd_ptr;
        w_wr_ptr_next      = r_wr_ptr;
        if (jump_flag_i) begin
            w_pc_next     = {jump_addr_i[31:2], 2'b00};
            w_count_next  = '0;
            w_rd_ptr_next = '0;
            w_wr_ptr_next = '0;
            // A response still in flight belongs to the old path and must be dropped.
            if (r_outstanding && !ibus_rvalid_i) begin
                w_discard_next = 1'b1;
            end else begin
                w_outstanding_next = 1'b0;
                w_discard_next     = 1'b0;
            end
        end else begin
            if (w_accept) begin
                w_pc_next          = r_pc + 32'd4;
                w_outstanding_next = 1'b1;
                w_out_addr_next    = r_pc;
            end else if (w_resp) begin
                w_outstanding_next = 1'b0;
            end
            if (w_resp && r_discard) begin
                w_discard_next = 1'b0;
            end
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                w_count_next = r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                w_count_next = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_ADDR;
            r_outstanding <= 1'b0;
            r_out_addr    <= 32'h0000_0000;
            r_discard     <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_outstanding <= w_outstanding_next;
            r_out_addr    <= w_out_addr_next;
            r_discard     <= w_discard_next;
            r_count       <= w_count_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_wr_ptr      <= w_wr_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_out_addr;
            r_fifo_inst[r_wr_ptr] <= ibus_rdata_i;
        end
    end

    // Read data with nothing in flight is a bus protocol violation.
    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) ibus_rvalid_i |-> r_outstanding
    );

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomised bench for if_fetch: bus responder with configurable latency,
// per-scenario tasks with inline checks, and a sequential-PC reference for random runs.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        hold_flag_i = 1'b0;
    logic        ibus_ack_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = 32'h0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_rvalid = 1'b0;
    logic [31:0] wr_rdata = 32'h0;
    logic        wr_valid;
    logic [31:0] wr_inst;
    logic [31:0] wr_iaddr;

    int n_pass  = 0;
    int n_total = 0;
    int mem_lat = 1;
    bit rand_lat = 1'b0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
        .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_ack_i(ibus_ack_i),
        .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
    );

    if_fetch #(.RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .jump_flag_i(1'b0), .jump_addr_i(32'h0), .hold_flag_i(1'b0),
        .ibus_req_o(wr_req), .ibus_addr_o(wr_addr), .ibus_ack_i(1'b1),
        .ibus_rvalid_i(wr_rvalid), .ibus_rdata_i(wr_rdata),
        .inst_valid_o(wr_valid), .inst_o(wr_inst), .inst_addr_o(wr_iaddr)
    );

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Single-slot responder: accept seen at mid-cycle, data returned mem_lat cycles later.
    bit          slot_v = 1'b0;
    logic [31:0] slot_addr = 32'h0;
    int          slot_wait = 0;
    logic        rst_s;
    always begin
        @(negedge clk);
        if (!rst) begin
            if (ibus_rvalid_i) slot_v = 1'b0;
            if (ibus_req_o && ibus_ack_i) begin
                slot_v    = 1'b1;
                slot_addr = ibus_addr_o;
                slot_wait = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            end
        end
        @(posedge clk);
        rst_s = rst;
        #1;
        if (rst_s) begin
            slot_v        = 1'b0;
            ibus_rvalid_i = 1'b0;
        end else begin
            if (slot_v && slot_wait > 0) slot_wait--;
            if (slot_v && slot_wait == 0) begin
                ibus_rvalid_i = 1'b1;
                ibus_rdata_i  = fdat(slot_addr);
            end else begin
                ibus_rvalid_i = 1'b0;
                ibus_rdata_i  = $urandom;
            end
        end
    end

    // Zero-wait responder for the wrap-around instance.
    logic        wr_acc = 1'b0;
    logic [31:0] wr_a = 32'h0;
    always begin
        @(negedge clk);
        wr_acc = wr_req;
        wr_a   = wr_addr;
        @(posedge clk);
        #1;
        wr_rvalid = wr_acc;
        wr_rdata  = fdat(wr_a);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int lat);
        @(posedge clk);
        #1;
        rst = 1'b1; jump_flag_i = 1'b0; hold_flag_i = 1'b0; ibus_ack_i = 1'b1;
        jump_addr_i = 32'h0; mem_lat = lat; rand_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; jump_flag_i = 1'b0; hold_flag_i = 1'b0; ibus_ack_i = 1'b1; mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (ibus_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", ibus_req_o); else n_pass++;
            n_total++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid_o); else n_pass++;
            n_total++; if (inst_o !== 32'h13) $display("FAIL reset_inst: got %h want 00000013", inst_o); else n_pass++;
            n_total++; if (inst_addr_o !== 32'h0) $display("FAIL reset_iaddr: got %h want 0", inst_addr_o); else n_pass++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (ibus_req_o !== 1'b1) $display("FAIL first_req: got %b want 1", ibus_req_o); else n_pass++;
        n_total++; if (ibus_addr_o !== 32'h0) $display("FAIL first_addr: got %h want 0", ibus_addr_o); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = 32'(4 * c);
            n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== e) $display("FAIL stream_req c=%0d: got %b/%h want 1/%h", c, ibus_req_o, ibus_addr_o, e); else n_pass++;
            if (c < 2) begin
                n_total++; if (inst_valid_o !== 1'b0) $display("FAIL stream_early c=%0d: got %b want 0", c, inst_valid_o); else n_pass++;
            end else begin
                e = 32'(4 * (c - 2));
                n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== e) $display("FAIL stream_head c=%0d: got %b/%h want 1/%h", c, inst_valid_o, inst_addr_o, e); else n_pass++;
                n_total++; if (inst_o !== fdat(e)) $display("FAIL stream_inst c=%0d: got %h want %h", c, inst_o, fdat(e)); else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
                n_total++; if (ibus_req_o !== 1'b0) $display("FAIL hold_req c=%0d: got %b want 0", c, ibus_req_o); else n_pass++;
                n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8) $display("FAIL hold_head c=%0d: got %b/%h want 1/00000008", c, inst_valid_o, inst_addr_o); else n_pass++;
            end else if (c >= 8) begin
                e = 32'(8 + 4 * (c - 8));
                n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== e || inst_o !== fdat(e)) $display("FAIL hold_resume c=%0d: got %b/%h/%h want 1/%h/%h", c, inst_valid_o, inst_addr_o, inst_o, e, fdat(e)); else n_pass++;
            end
            @(posedge clk);
            #1 hold_flag_i = (c + 1 >= 4 && c + 1 <= 7);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset(3);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            case (c)
                4: begin
                    n_total++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_o !== 32'h0) $display("FAIL jump_outputs: got %b/%h/%h want 0/00000013/0", inst_valid_o, inst_o, inst_addr_o); else n_pass++;
                    n_total++; if (ibus_req_o !== 1'b0) $display("FAIL jump_req: got %b want 0", ibus_req_o); else n_pass++;
                end
                5: begin
                    n_total++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h100) $display("FAIL jump_wait: got %b/%h want 0/00000100", ibus_req_o, ibus_addr_o); else n_pass++;
                end
                6: begin
                    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100) $display("FAIL jump_target_req: got %b/%h want 1/00000100", ibus_req_o, ibus_addr_o); else n_pass++;
                end
                7, 8, 9, 11: begin
                    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL jump_stale c=%0d: got %b want 0", c, inst_valid_o); else n_pass++;
                end
                10: begin
                    n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== fdat(32'h100)) $display("FAIL jump_first: got %b/%h/%h want 1/00000100/%h", inst_valid_o, inst_addr_o, inst_o, fdat(32'h100)); else n_pass++;
                end
                13: begin
                    n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h104 || inst_o !== fdat(32'h104)) $display("FAIL jump_second: got %b/%h/%h want 1/00000104/%h", inst_valid_o, inst_addr_o, inst_o, fdat(32'h104)); else n_pass++;
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
            jump_flag_i = (c + 1 == 4);
            jump_addr_i = 32'h100;
        end
    endtask

    // Jump while the previous response returns; with_hold also stalls in the same cycle.
    task automatic test_redirect_now(input bit with_hold, input logic [31:0] tgt_raw,
                                     input logic [31:0] tgt);
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            case (c)
                3: begin
                    n_total++; if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0) $display("FAIL jnow_cycle h=%0d: got %b/%b want 0/0", with_hold, inst_valid_o, ibus_req_o); else n_pass++;
                end
                4: begin
                    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL jnow_empty h=%0d: got %b want 0", with_hold, inst_valid_o); else n_pass++;
                    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== tgt) $display("FAIL jnow_pc h=%0d: got %b/%h want 1/%h", with_hold, ibus_req_o, ibus_addr_o, tgt); else n_pass++;
                end
                5: begin
                    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL jnow_nopush h=%0d: got %b want 0", with_hold, inst_valid_o); else n_pass++;
                end
                6, 7: begin
                    n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== tgt + 32'(4 * (c - 6)) || inst_o !== fdat(tgt + 32'(4 * (c - 6)))) $display("FAIL jnow_head h=%0d c=%0d: got %b/%h/%h want 1/%h", with_hold, c, inst_valid_o, inst_addr_o, inst_o, tgt + 32'(4 * (c - 6))); else n_pass++;
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
            jump_flag_i = (c + 1 == 3);
            hold_flag_i = with_hold && (c + 1 == 3);
            jump_addr_i = tgt_raw;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_total++; if (wr_req !== 1'b1 || wr_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_req: got %b/%h want 1/fffffff8", wr_req, wr_addr); else n_pass++;
            end else if (c >= 2) begin
                e = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
                n_total++; if (wr_valid !== 1'b1 || wr_iaddr !== e || wr_inst !== fdat(e)) $display("FAIL wrap_head c=%0d: got %b/%h/%h want 1/%h/%h", c, wr_valid, wr_iaddr, wr_inst, e, fdat(e)); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        int live;
        int max_live;
        int delivered;
        do_reset(1);
        rand_lat  = 1'b1;
        exp_next  = 32'h0;
        live      = 0;
        max_live  = 0;
        delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (jump_flag_i) begin
                n_total++; if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0) $display("FAIL rand_jump c=%0d: got %b/%b want 0/0", c, inst_valid_o, ibus_req_o); else n_pass++;
                exp_next = {jump_addr_i[31:2], 2'b00};
                live     = 0;
            end else begin
                if (inst_valid_o && !hold_flag_i) begin
                    n_total++; if (inst_addr_o !== exp_next || inst_o !== fdat(exp_next)) $display("FAIL rand_seq c=%0d: got %h/%h want %h/%h", c, inst_addr_o, inst_o, exp_next, fdat(exp_next)); else n_pass++;
                    exp_next = exp_next + 32'd4;
                    live--;
                    delivered++;
                end
                if (ibus_req_o && ibus_ack_i) live++;
                if (live > max_live) max_live = live;
            end
            @(posedge clk);
            #1;
            ibus_ack_i  = ($urandom_range(0, 3) != 0);
            hold_flag_i = ($urandom_range(0, 4) == 0);
            jump_flag_i = ($urandom_range(0, 31) == 0);
            jump_addr_i = $urandom;
        end
        @(posedge clk);
        #1;
        jump_flag_i = 1'b0; hold_flag_i = 1'b0; rand_lat = 1'b0;
        n_total++; if (max_live > 2) $display("FAIL rand_credit: got %0d in flight+buffered want <= 2", max_live); else n_pass++;
        n_total++; if (delivered < 500) $display("FAIL rand_progress: got %0d delivered want >= 500", delivered); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_hold();
        test_redirect_pending();
        test_redirect_now(1'b0, 32'h0000_0103, 32'h0000_0100);
        test_redirect_now(1'b1, 32'h0000_0200, 32'h0000_0200);
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
